// File: rtl/request_encoder_eight_to_three_if.sv
// Request/code channel for the 8-to-3 request encoder.
// The slave modport is the encoder side; the master modport is the request source and code consumer.
interface request_encoder_eight_to_three_if;
    logic [7:0] req;
    logic       code_valid;
    logic [2:0] code;
    logic       code_ready;
    logic [7:0] pending;
    logic       overflow;

    modport master (
        output req,
        output code_ready,
        input  code_valid,
        input  code,
        input  pending,
        input  overflow
    );

    modport slave (
        input  req,
        input  code_ready,
        output code_valid,
        output code,
        output pending,
        output overflow
    );
endinterface

// File: rtl/request_encoder_eight_to_three.sv
// Sequential 8-to-3 encoder: latches request pulses into a pending vector and emits
// one 3-bit code per pending bit over a valid/ready handshake.
module request_encoder_eight_to_three #(
    parameter int ROUND_ROBIN = 0
) (
    input logic                                 clk,
    input logic                                 rst_n,
    request_encoder_eight_to_three_if.slave     bus
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t     state;
    logic [7:0] pending_q;
    logic [2:0] code_q;
    logic [2:0] last_q;
    logic       valid_q;
    logic       overflow_q;

    logic       handshake;
    logic [7:0] served;
    logic [7:0] cand;
    logic [2:0] base;
    logic [2:0] idx;
    logic [2:0] sel;

    always_comb begin
        handshake    = valid_q & bus.code_ready;
        served       = '0;
        if (handshake) begin
            served[code_q] = 1'b1;
        end
        // Same-cycle req never competes; the presented bit drops out only on its handshake.
        cand = pending_q & ~served;
        // On a handshake the accepted code becomes last_served this very edge.
        base = handshake ? code_q + 3'd1 : last_q + 3'd1;
        sel  = '0;
        idx  = '0;
        if (ROUND_ROBIN != 0) begin
            // Descending offset so the nearest bit after base is the last writer.
            for (int unsigned off = 8; off > 0; off--) begin
                idx = base + 3'(off - 1);
                if (cand[idx]) begin
                    sel = idx;
                end
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (cand[i]) begin
                    sel = 3'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending_q  <= '0;
            code_q     <= '0;
            last_q     <= 3'd7;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= cand | bus.req;
            overflow_q <= |(bus.req & cand);
            case (state)
                IDLE: begin
                    if (|pending_q) begin
                        code_q  <= sel;
                        valid_q <= 1'b1;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (handshake) begin
                        last_q <= code_q;
                        if (|cand) begin
                            code_q <= sel;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.code_valid = valid_q;
    assign bus.code       = code_q;
    assign bus.pending    = pending_q;
    assign bus.overflow   = overflow_q;

endmodule
